// File: rtl/teensy_link_pkg.sv
// Constants shared by the Teensy link transmit and receive sides.
package teensy_link_pkg;

    localparam logic [7:0] HEADER         = 8'hFF;
    localparam int         FRAME_BYTES    = 4;
    localparam int         POSTI_BYTES    = 4;
    localparam int         UART_BIT_WIDTH = 8;
    localparam int         PACKET_LEN     = 1 + FRAME_BYTES + POSTI_BYTES;

    localparam int         IDX_W = $clog2((FRAME_BYTES > POSTI_BYTES) ? FRAME_BYTES : POSTI_BYTES);

    localparam logic [1:0] P_WAIT_HDR = 2'd0;
    localparam logic [1:0] P_FRAME    = 2'd1;
    localparam logic [1:0] P_POSTI    = 2'd2;

endpackage

// File: rtl/rs232c_receiver.sv
// RS-232C character receiver: 8N1-style, LSB first, bit period latched at each start edge.
//
// state    | meaning
// RX_IDLE  | waiting for a falling edge on an armed (previously high) line
// RX_START | half-bit wait, then confirm start bit is still low
// RX_DATA  | sampling BIT_WIDTH data bits, one per bit period
// RX_STOP  | sampling the stop bit; high -> r_valid, low -> r_err
module rs232c_receiver #(
    parameter int BIT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 rxd,
    input  logic [31:0]          max_count,
    output logic [BIT_WIDTH-1:0] recv_data,
    output logic                 r_valid,
    output logic                 r_err
);

    localparam int BIT_IDX_W = $clog2(BIT_WIDTH + 1);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    logic [1:0]           state;
    logic                 rxd_s1;
    logic                 rxd_s2;
    logic [1:0]           sync_fill;
    logic                 armed;
    logic [31:0]          bit_period;
    logic [31:0]          bit_cnt;
    logic [BIT_IDX_W-1:0] bit_idx;
    logic [BIT_WIDTH-1:0] shift;
    logic                 sample;

    assign sample = (bit_cnt == 32'd0);

    // The synchroniser resets high, so its output is only trusted for arming once
    // real line samples have propagated through both flops.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= RX_IDLE;
            rxd_s1     <= 1'b1;
            rxd_s2     <= 1'b1;
            sync_fill  <= 2'b00;
            armed      <= 1'b0;
            bit_period <= 32'd0;
            bit_cnt    <= 32'd0;
            bit_idx    <= '0;
            shift      <= '0;
            recv_data  <= '0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            rxd_s1    <= rxd;
            rxd_s2    <= rxd_s1;
            sync_fill <= {sync_fill[0], 1'b1};
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
            if (bit_cnt != 32'd0) begin
                bit_cnt <= bit_cnt - 32'd1;
            end

            case (state)
                RX_IDLE: begin
                    if (armed && !rxd_s2) begin
                        state      <= RX_START;
                        armed      <= 1'b0;
                        bit_period <= max_count;
                        bit_cnt    <= (max_count >> 1) - 32'd1;
                    end else if (sync_fill[1] && rxd_s2) begin
                        armed <= 1'b1;
                    end
                end
                RX_START: begin
                    if (sample) begin
                        if (rxd_s2) begin
                            state <= RX_IDLE;
                        end else begin
                            state   <= RX_DATA;
                            bit_cnt <= bit_period - 32'd1;
                            bit_idx <= '0;
                        end
                    end
                end
                RX_DATA: begin
                    if (sample) begin
                        shift   <= {rxd_s2, shift[BIT_WIDTH-1:1]};
                        bit_cnt <= bit_period - 32'd1;
                        if (bit_idx == BIT_IDX_W'(BIT_WIDTH - 1)) begin
                            state <= RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                RX_STOP: begin
                    if (sample) begin
                        state <= RX_IDLE;
                        if (rxd_s2) begin
                            r_valid   <= 1'b1;
                            recv_data <= shift;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/teensy_packet_receiver.sv
// Teensy link packet decoder: header 0xFF, then frame number and position, each LSB byte first.
//
// state      | meaning
// P_WAIT_HDR | dropping bytes until a HEADER byte arrives
// P_FRAME    | collecting frame-number bytes into the shadow register
// P_POSTI    | collecting position bytes; last byte publishes the packet
module teensy_packet_receiver
    import teensy_link_pkg::*;
(
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     Rxd,
    input  logic [31:0]              RxdMaxCount,
    input  logic [31:0]              TimeoutCount,
    output logic [FRAME_BYTES*8-1:0] FrameNum,
    output logic [POSTI_BYTES*8-1:0] PostiData,
    output logic                     DataValid,
    output logic                     SeqError,
    output logic                     FrameError,
    output logic                     TimeoutError
);

    logic [UART_BIT_WIDTH-1:0] rx_byte;
    logic                      byte_valid;
    logic                      byte_err;

    logic [1:0]                state;
    logic [IDX_W-1:0]          byte_idx;
    logic [FRAME_BYTES*8-1:0]  frame_sh;
    logic [POSTI_BYTES*8-1:0]  posti_sh;
    logic [POSTI_BYTES*8-1:0]  posti_next;
    logic                      first_pkt;
    logic [31:0]               to_cnt;
    logic                      timeout_hit;

    rs232c_receiver #(
        .BIT_WIDTH (UART_BIT_WIDTH)
    ) u_rx (
        .clk       (clk),
        .n_rst     (n_rst),
        .rxd       (Rxd),
        .max_count (RxdMaxCount),
        .recv_data (rx_byte),
        .r_valid   (byte_valid),
        .r_err     (byte_err)
    );

    // An arriving byte (good or bad) always takes precedence over the timeout.
    always_comb begin
        timeout_hit = (state != P_WAIT_HDR) && (TimeoutCount != 32'd0) &&
                      (to_cnt == TimeoutCount) && !byte_valid && !byte_err;
    end

    assign TimeoutError = timeout_hit;

    always_comb begin
        posti_next = posti_sh;
        posti_next[{byte_idx, 3'b000} +: 8] = rx_byte;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= P_WAIT_HDR;
            byte_idx   <= '0;
            frame_sh   <= '0;
            posti_sh   <= '0;
            first_pkt  <= 1'b1;
            to_cnt     <= 32'd0;
            FrameNum   <= '0;
            PostiData  <= '0;
            DataValid  <= 1'b0;
            SeqError   <= 1'b0;
            FrameError <= 1'b0;
        end else begin
            DataValid  <= 1'b0;
            SeqError   <= 1'b0;
            FrameError <= 1'b0;

            if (state == P_WAIT_HDR || byte_valid) begin
                to_cnt <= 32'd0;
            end else begin
                to_cnt <= to_cnt + 32'd1;
            end

            if (byte_err) begin
                FrameError <= 1'b1;
                state      <= P_WAIT_HDR;
            end else if (byte_valid) begin
                case (state)
                    P_WAIT_HDR: begin
                        if (rx_byte == HEADER) begin
                            state    <= P_FRAME;
                            byte_idx <= '0;
                        end
                    end
                    P_FRAME: begin
                        frame_sh[{byte_idx, 3'b000} +: 8] <= rx_byte;
                        if (byte_idx == IDX_W'(FRAME_BYTES - 1)) begin
                            state    <= P_POSTI;
                            byte_idx <= '0;
                        end else begin
                            byte_idx <= byte_idx + 1'b1;
                        end
                    end
                    P_POSTI: begin
                        posti_sh <= posti_next;
                        if (byte_idx == IDX_W'(POSTI_BYTES - 1)) begin
                            state     <= P_WAIT_HDR;
                            FrameNum  <= frame_sh;
                            PostiData <= posti_next;
                            DataValid <= 1'b1;
                            SeqError  <= !first_pkt && (frame_sh != FrameNum + 1'b1);
                            first_pkt <= 1'b0;
                        end else begin
                            byte_idx <= byte_idx + 1'b1;
                        end
                    end
                    default: state <= P_WAIT_HDR;
                endcase
            end else if (timeout_hit) begin
                state <= P_WAIT_HDR;
            end
        end
    end

endmodule

// File: tb/tb_teensy_packet_receiver.sv
// Self-checking bench for teensy_packet_receiver: serial stimulus, scoreboard of expected packets.
module tb_teensy_packet_receiver;
    import teensy_link_pkg::*;

    typedef struct packed {
        logic [31:0] frame;
        logic [31:0] posti;
        logic        seq;
    } exp_t;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        Rxd = 1'b1;
    logic [31:0] RxdMaxCount = 32'd16;
    logic [31:0] TimeoutCount = 32'd0;
    logic [31:0] FrameNum;
    logic [31:0] PostiData;
    logic        DataValid;
    logic        SeqError;
    logic        FrameError;
    logic        TimeoutError;

    int   total = 0;
    int   bad = 0;
    int   dv_cnt = 0;
    int   fe_cnt = 0;
    int   te_cnt = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    logic [31:0] m_prev = 32'd0;
    bit   m_first = 1'b1;

    teensy_packet_receiver dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .Rxd          (Rxd),
        .RxdMaxCount  (RxdMaxCount),
        .TimeoutCount (TimeoutCount),
        .FrameNum     (FrameNum),
        .PostiData    (PostiData),
        .DataValid    (DataValid),
        .SeqError     (SeqError),
        .FrameError   (FrameError),
        .TimeoutError (TimeoutError)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (n_rst) begin
            if (FrameError) fe_cnt++;
            if (TimeoutError) te_cnt++;
            if (FrameError || TimeoutError || SeqError)
                chk("err_excl", 32'(FrameError) + 32'(TimeoutError) + 32'(SeqError), 32'd1);
            if (DataValid) begin
                dv_cnt++;
                if (exp_q.size() == 0) begin
                    chk("dv_unexpected", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("frame", FrameNum, mon_e.frame);
                    chk("posti", PostiData, mon_e.posti);
                    chk("seq", 32'(SeqError), 32'(mon_e.seq));
                end
            end else if (SeqError) begin
                chk("seq_without_dv", 32'd1, 32'd0);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        Rxd = 1'b0;
        repeat (RxdMaxCount) @(negedge clk);
        for (int i = 0; i < UART_BIT_WIDTH; i++) begin
            Rxd = b[i];
            repeat (RxdMaxCount) @(negedge clk);
        end
        Rxd = stop_ok;
        repeat (RxdMaxCount) @(negedge clk);
        Rxd = 1'b1;
        if (!stop_ok) repeat (RxdMaxCount) @(negedge clk);
    endtask

    task automatic push_exp(input logic [31:0] frame, input logic [31:0] posti);
        exp_t e;
        e.frame = frame;
        e.posti = posti;
        e.seq   = !m_first && (frame != m_prev + 32'd1);
        exp_q.push_back(e);
        m_prev  = frame;
        m_first = 1'b0;
    endtask

    task automatic send_pkt(input logic [31:0] frame, input logic [31:0] posti);
        logic [63:0] pl;
        pl = {posti, frame};
        push_exp(frame, posti);
        send_byte(HEADER, 1'b1);
        for (int i = 0; i < PACKET_LEN - 1; i++) send_byte(pl[8*i +: 8], 1'b1);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_frame"}, FrameNum, 32'd0);
        chk({tag, "_posti"}, PostiData, 32'd0);
        chk({tag, "_pulses"}, {28'd0, DataValid, SeqError, FrameError, TimeoutError}, 32'd0);
    endtask

    initial begin
        repeat (4) @(negedge clk);
        chk_zero_outputs("reset");
        n_rst = 1'b1;
        repeat (5) @(negedge clk);

        // basic packet, first after reset: no sequence check
        send_pkt(32'h0000_0001, 32'h1234_5678);
        wait_drain("drain_basic");
        chk("dv_basic", 32'(dv_cnt), 32'd1);

        // wrap-around sequence, then a jump
        send_pkt(32'hFFFF_FFFF, 32'hAAAA_0000);
        send_pkt(32'h0000_0000, 32'h0000_0001);
        send_pkt(32'h0000_0005, 32'h0000_0002);
        wait_drain("drain_seq");
        chk("dv_seq", 32'(dv_cnt), 32'd4);

        // garbage before the header, 0xFF embedded in the position field
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send_pkt(32'h0000_0006, 32'h00FF_1122);
        wait_drain("drain_garbage");
        chk("dv_garbage", 32'(dv_cnt), 32'd5);

        // bad stop bit on byte 5
        send_byte(HEADER, 1'b1);
        send_byte(8'h07, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b0);
        repeat (5) @(negedge clk);
        chk("fe_count", 32'(fe_cnt), 32'd1);
        chk("fe_frame_kept", FrameNum, 32'h0000_0006);
        chk("fe_posti_kept", PostiData, 32'h00FF_1122);
        send_pkt(32'h0000_0007, 32'h0000_0033);
        wait_drain("drain_after_fe");
        chk("dv_after_fe", 32'(dv_cnt), 32'd6);

        // inter-byte timeout enabled
        TimeoutCount = 32'd200;
        send_byte(HEADER, 1'b1);
        send_byte(8'h08, 1'b1);
        send_byte(8'h00, 1'b1);
        repeat (400) @(negedge clk);
        chk("te_count", 32'(te_cnt), 32'd1);
        chk("te_frame_kept", FrameNum, 32'h0000_0007);
        chk("dv_during_te", 32'(dv_cnt), 32'd6);
        send_pkt(32'h0000_0008, 32'h0000_0044);
        wait_drain("drain_after_te");
        chk("dv_after_te", 32'(dv_cnt), 32'd7);

        // timeout disabled: stalled packet resumes and completes
        TimeoutCount = 32'd0;
        push_exp(32'h0000_0009, 32'h0000_0055);
        send_byte(HEADER, 1'b1);
        send_byte(8'h09, 1'b1);
        send_byte(8'h00, 1'b1);
        repeat (400) @(negedge clk);
        chk("te_disabled", 32'(te_cnt), 32'd1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h55, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        wait_drain("drain_te_off");
        chk("dv_te_off", 32'(dv_cnt), 32'd8);

        // reset during byte 6
        TimeoutCount = 32'd200;
        send_byte(HEADER, 1'b1);
        send_byte(8'h0A, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        Rxd = 1'b0;
        repeat (40) @(negedge clk);
        n_rst = 1'b0;
        m_first = 1'b1;
        repeat (3) @(negedge clk);
        Rxd = 1'b1;
        n_rst = 1'b1;
        repeat (20) @(negedge clk);

        // short low glitch on an idle line
        Rxd = 1'b0;
        repeat (4) @(negedge clk);
        Rxd = 1'b1;
        repeat (40) @(negedge clk);

        // line held low through reset release
        Rxd = 1'b0;
        n_rst = 1'b0;
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        repeat (100) @(negedge clk);
        Rxd = 1'b1;
        repeat (40) @(negedge clk);

        chk_zero_outputs("post_reset");
        chk("dv_post_reset", 32'(dv_cnt), 32'd8);
        chk("fe_post_reset", 32'(fe_cnt), 32'd1);
        chk("te_post_reset", 32'(te_cnt), 32'd1);

        send_pkt(32'h0000_0010, 32'h0000_0066);
        wait_drain("drain_final");
        chk("dv_final", 32'(dv_cnt), 32'd9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
